// File: rtl/spi_regbank.sv
// spi_regbank -- SPI mode-0 slave giving a host read/write access to a bank
// of NUM_REGS control registers, DATA_W bits each, with burst auto-increment.
//
// Frame: 8-bit command (bit7 = 1 write / 0 read, bits[6:0] = start address),
// then one or more DATA_W-bit words, all MSB first. The address advances by
// one after every word and wraps 7'h7F -> 7'h00.
//   7'h7E : status; bit0 = frame_err (read), any write clears frame_err
//   7'h7F : read-only ID word
//
// Ports
//   clk_clk        in   system clock, all logic on its rising edge
//   reset_reset_n  in   asynchronous active-low reset
//   spi_sclk       in   SPI clock (asynchronous, at most clk_clk/8)
//   spi_nss        in   SPI chip select, active low
//   spi_mosi       in   SPI data from host
//   spi_miso       out  SPI data to host
//   spi_miso_oe    out  MISO drive enable for the external tri-state buffer
//   regs_out       out  register contents, reg k at [k*DATA_W +: DATA_W]
//   wr_strobe      out  one-cycle pulse per register on the cycle it updates
//   frame_err      out  sticky: bad write address or truncated write word
module spi_regbank #(
  parameter int                NUM_REGS  = 5,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter logic [31:0]       ID_VAL    = 32'h5244_0001
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset_n,
  input  logic                       spi_sclk,
  input  logic                       spi_nss,
  input  logic                       spi_mosi,
  output logic                       spi_miso,
  output logic                       spi_miso_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err
);

  localparam int                CNT_W  = $clog2(DATA_W) + 1;
  localparam logic [7:0]        NREG   = 8'(NUM_REGS);
  localparam logic [DATA_W-1:0] ID_W   = ID_VAL[DATA_W-1:0];
  localparam logic [6:0]        A_STAT = 7'h7E;
  localparam logic [6:0]        A_ID   = 7'h7F;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t state, state_nxt;

  // synchroniser chains: _p0/_p1 are the two metastability flops, _p2 is
  // the one-cycle-old copy used for edge detection
  logic sclk_p0, sclk_p1, sclk_p2;
  logic nss_p0, nss_p1, nss_p2;
  logic mosi_p0, mosi_p1;
  logic [2:0] warm;

  logic sclk_rise, sclk_fall, nss_fall;
  logic nss_s, mosi_s;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shin;
  logic [DATA_W-1:0] shout;
  logic [DATA_W-1:0] rd_val;
  logic [6:0]        addr;
  logic              rw;
  logic              commit_pend;
  logic              load_pend;
  logic              mapped;

  logic frame_start, cmd_done, word_end, part_abort;

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      nss_p0  <= 1'b1;
      nss_p1  <= 1'b1;
      nss_p2  <= 1'b1;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
      warm    <= 3'b000;
    end else begin
      sclk_p0 <= spi_sclk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      nss_p0  <= spi_nss;
      nss_p1  <= nss_p0;
      nss_p2  <= nss_p1;
      mosi_p0 <= spi_mosi;
      mosi_p1 <= mosi_p0;
      warm    <= {warm[1:0], 1'b1};
    end
  end

  assign nss_s     = nss_p1;
  assign mosi_s    = mosi_p1;
  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign sclk_fall = ~sclk_p1 & sclk_p2;
  // The nss chain resets to "deselected". If nss is actually held low across
  // reset release, the flush of those reset values must not look like a
  // falling edge, so a frame only starts once the whole chain holds real
  // samples; the rest of that frame is then ignored until nss toggles.
  assign nss_fall  = warm[2] & nss_p2 & ~nss_p1;

  assign spi_miso_oe = ~nss_s;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    cmd_done    = 1'b0;
    word_end    = 1'b0;
    part_abort  = 1'b0;
    unique case (state)
      IDLE: begin
        if (nss_fall) begin
          frame_start = 1'b1;
          state_nxt   = CMD;
        end
      end
      CMD: begin
        if (nss_s) begin
          state_nxt = IDLE;
        end else if (sclk_rise && (cnt == CNT_W'(7))) begin
          cmd_done  = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (nss_s) begin
          state_nxt  = IDLE;
          part_abort = rw && (cnt != '0);
        end else if (sclk_rise && (cnt == CNT_W'(DATA_W - 1))) begin
          word_end = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mapped = ({1'b0, addr} < NREG);

  // mapped registers take priority over the status/ID addresses, which only
  // matters when NUM_REGS reaches 127
  always_comb begin
    rd_val = '0;
    if (addr == A_ID)        rd_val = ID_W;
    else if (addr == A_STAT) rd_val = {{(DATA_W-1){1'b0}}, frame_err};
    for (int k = 0; k < NUM_REGS; k++) begin
      if (addr == 7'(k)) rd_val = regs[k];
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt         <= '0;
      shin        <= '0;
      shout       <= '0;
      addr        <= '0;
      rw          <= 1'b0;
      commit_pend <= 1'b0;
      load_pend   <= 1'b0;
      spi_miso    <= 1'b0;
      frame_err   <= 1'b0;
      wr_strobe   <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VAL;
    end else begin
      wr_strobe <= '0;

      if (frame_start) begin
        cnt <= '0;
      end else if (sclk_rise && (state != IDLE)) begin
        cnt  <= (cmd_done || word_end) ? '0 : cnt + CNT_W'(1);
        shin <= {shin[DATA_W-2:0], mosi_s};
      end

      // command byte complete: bit7 is already in shin[6], the last address
      // bit is still on the synchronised MOSI line
      if (cmd_done) begin
        rw        <= shin[6];
        addr      <= {shin[5:0], mosi_s};
        load_pend <= ~shin[6];
      end

      if (word_end) commit_pend <= 1'b1;

      // the shift-out reload waits one cycle after the address step so it
      // sees both the new address and any register just committed
      if (load_pend) load_pend <= 1'b0;

      if (commit_pend) begin
        commit_pend <= 1'b0;
        addr        <= addr + 7'd1;
        load_pend   <= ~rw;
        if (rw) begin
          for (int k = 0; k < NUM_REGS; k++) begin
            if (addr == 7'(k)) begin
              regs[k]      <= shin;
              wr_strobe[k] <= 1'b1;
            end
          end
          if (!mapped) begin
            if (addr == A_STAT) frame_err <= 1'b0;
            else                frame_err <= 1'b1;
          end
        end
      end

      if (part_abort) frame_err <= 1'b1;

      // MISO stays low through the command byte and only shifts in DATA
      if (frame_start) begin
        shout    <= '0;
        spi_miso <= 1'b0;
      end else if (load_pend) begin
        shout <= rd_val;
      end else if (sclk_fall && (state == DATA)) begin
        spi_miso <= shout[DATA_W-1];
        shout    <= {shout[DATA_W-2:0], 1'b0};
      end

      if (state == IDLE && !frame_start) spi_miso <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    assign regs_out[k*DATA_W +: DATA_W] = regs[k];
  end

endmodule
